// File: rtl/ball_plotter_if.sv
// Pixel-plotter handshake: frame request and position in, VGA pixel stream and status out.
// The master side is the position/tick logic; the slave side is ball_plotter.
interface ball_plotter_if;
   logic       enable;
   logic [7:0] x_in;
   logic [6:0] y_in;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot;
   logic       busy;
   logic       done;

   modport master (output enable, x_in, y_in,
                   input  x, y, colour, plot, busy, done);
   modport slave  (input  enable, x_in, y_in,
                   output x, y, colour, plot, busy, done);
endinterface

// File: rtl/ball_plotter.sv
// Redraws a SIZE x SIZE ball per frame tick: erases the previous square, then draws the new one,
// streaming one registered pixel per cycle to the VGA adapter with off-screen pixels suppressed.
module ball_plotter #(
   parameter int         SIZE        = 2,
   parameter logic [2:0] BALL_COLOUR = 3'b111,
   parameter logic [2:0] BG_COLOUR   = 3'b000
) (
   input logic          clk,
   input logic          reset,
   ball_plotter_if.slave bus
);

   localparam int             CW   = (SIZE > 1) ? $clog2(SIZE) : 1;
   localparam logic [CW-1:0]  LAST = CW'(SIZE - 1);

   typedef enum logic [2:0] {IDLE, LOAD, ERASE, DRAW, FIN} state_t;

   state_t        state, state_next;
   logic [CW-1:0] dx, dy;
   logic          prev_valid;
   logic [7:0]    old_x, new_x;
   logic [6:0]    old_y, new_y;

   logic [8:0]    sum_x;
   logic [7:0]    sum_y;
   logic          on_screen;
   logic          last_px;
   logic [2:0]    pass_colour;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_next  = state;
      sum_x       = {1'b0, new_x} + 9'(dx);
      sum_y       = {1'b0, new_y} + 8'(dy);
      pass_colour = BALL_COLOUR;
      if (state == ERASE) begin
         sum_x       = {1'b0, old_x} + 9'(dx);
         sum_y       = {1'b0, old_y} + 8'(dy);
         pass_colour = BG_COLOUR;
      end
      on_screen = (sum_x <= 9'd159) && (sum_y <= 8'd119);
      last_px   = (dx == LAST) && (dy == LAST);

      case (state)
         IDLE:    if (bus.enable) state_next = LOAD;
         LOAD:    state_next = prev_valid ? ERASE : DRAW;
         ERASE:   if (last_px) state_next = DRAW;
         DRAW:    if (last_px) state_next = FIN;
         FIN:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dx         <= '0;
         dy         <= '0;
         prev_valid <= 1'b0;
         old_x      <= '0;
         old_y      <= '0;
         new_x      <= '0;
         new_y      <= '0;
         bus.x      <= '0;
         bus.y      <= '0;
         bus.colour <= '0;
         bus.plot   <= 1'b0;
         bus.busy   <= 1'b0;
         bus.done   <= 1'b0;
      end else begin
         bus.plot <= 1'b0;
         bus.busy <= (state_next != IDLE);
         bus.done <= (state_next == FIN);

         case (state)
            IDLE: begin
               if (bus.enable) begin
                  new_x <= bus.x_in;
                  new_y <= bus.y_in;
               end
            end
            LOAD: begin
               dx <= '0;
               dy <= '0;
            end
            ERASE, DRAW: begin
               // Clipped pixels still use their slot; x/y/colour hold their last plotted values.
               if (on_screen) begin
                  bus.x      <= sum_x[7:0];
                  bus.y      <= sum_y[6:0];
                  bus.colour <= pass_colour;
                  bus.plot   <= 1'b1;
               end
               if (dx == LAST) begin
                  dx <= '0;
                  dy <= (dy == LAST) ? '0 : dy + CW'(1);
               end else begin
                  dx <= dx + CW'(1);
               end
               if (state == DRAW && last_px) begin
                  old_x      <= new_x;
                  old_y      <= new_y;
                  prev_valid <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ball_plotter.sv
// Scoreboard bench for ball_plotter: SIZE=2 and SIZE=1 instances, expected pixels queued at
// stimulus time and popped as plot pulses appear.
module tb_ball_plotter;

   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
   } pix_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_b;
   ball_plotter_if ba ();
   ball_plotter_if bb ();

   ball_plotter #(.SIZE(2), .BALL_COLOUR(3'b111), .BG_COLOUR(3'b000)) dut_a (
      .clk(clk), .reset(rst_a), .bus(ba));
   ball_plotter #(.SIZE(1), .BALL_COLOUR(3'b111), .BG_COLOUR(3'b000)) dut_b (
      .clk(clk), .reset(rst_b), .bus(bb));

   int   sel;
   logic [7:0] mon_x;
   logic [6:0] mon_y;
   logic [2:0] mon_c;
   logic       mon_plot, mon_busy, mon_done;

   always_comb begin
      mon_x    = sel ? bb.x      : ba.x;
      mon_y    = sel ? bb.y      : ba.y;
      mon_c    = sel ? bb.colour : ba.colour;
      mon_plot = sel ? bb.plot   : ba.plot;
      mon_busy = sel ? bb.busy   : ba.busy;
      mon_done = sel ? bb.done   : ba.done;
   end

   int   n_checks = 0;
   int   n_fail   = 0;
   pix_t sb[$];
   bit   m_prev[2];
   int   m_ox[2], m_oy[2];

   int n_plot, first_i, last_i, done_i, n_done;

   task automatic push_pass(input int bx, input int by, input logic [2:0] c, input int s);
      for (int dy = 0; dy < s; dy++)
         for (int dx = 0; dx < s; dx++)
            if (bx + dx <= 159 && by + dy <= 119)
               sb.push_back(pix_t'{8'(bx + dx), 7'(by + dy), c});
   endtask

   // Queue the expected erase/draw pixels, then pulse enable for one edge.
   task automatic start(input int px, input int py);
      int s;
      s = sel ? 1 : 2;
      if (m_prev[sel]) push_pass(m_ox[sel], m_oy[sel], 3'b000, s);
      push_pass(px, py, 3'b111, s);
      m_prev[sel] = 1'b1;
      m_ox[sel]   = px;
      m_oy[sel]   = py;
      @(negedge clk);
      if (sel == 0) begin ba.enable = 1'b1; ba.x_in = 8'(px); ba.y_in = 7'(py); end
      else          begin bb.enable = 1'b1; bb.x_in = 8'(px); bb.y_in = 7'(py); end
      @(negedge clk);
      ba.enable = 1'b0;
      bb.enable = 1'b0;
   endtask

   // Index 0 is the negedge after the enable edge; pops the scoreboard on every plot.
   task automatic drain(input int inject_idx, input int tail);
      pix_t e;
      n_plot = 0; first_i = -1; last_i = -1; done_i = -1; n_done = 0;
      for (int i = 0; i < 60; i++) begin
         if (mon_plot) begin
            n_plot++;
            if (first_i < 0) first_i = i;
            last_i = i;
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL extra_plot sel=%0d i=%0d got (%0d,%0d,%b) want none", sel, i, mon_x, mon_y, mon_c);
            end else begin
               e = sb.pop_front();
               if ({mon_x, mon_y, mon_c} !== e) begin
                  n_fail++;
                  $display("FAIL pixel sel=%0d i=%0d got (%0d,%0d,%b) want (%0d,%0d,%b)",
                           sel, i, mon_x, mon_y, mon_c, e.x, e.y, e.c);
               end
            end
         end
         if (mon_done) begin
            n_done++;
            if (done_i < 0) done_i = i;
         end
         if (i == inject_idx) begin ba.enable = 1'b1; ba.x_in = 8'd90; ba.y_in = 7'd60; end
         if (i == inject_idx + 1) ba.enable = 1'b0;
         if (done_i >= 0 && i >= done_i + tail) break;
         @(negedge clk);
      end
   endtask

   task automatic frame_checks(input string nm, input int plots, input int first, input int last, input int dn);
      n_checks++; if (n_plot !== plots) begin n_fail++; $display("FAIL %s plots got %0d want %0d", nm, n_plot, plots); end
      n_checks++; if (first_i !== first) begin n_fail++; $display("FAIL %s first_plot got %0d want %0d", nm, first_i, first); end
      n_checks++; if (last_i !== last) begin n_fail++; $display("FAIL %s last_plot got %0d want %0d", nm, last_i, last); end
      n_checks++; if (done_i !== dn) begin n_fail++; $display("FAIL %s done_at got %0d want %0d", nm, done_i, dn); end
      n_checks++; if (n_done !== 1) begin n_fail++; $display("FAIL %s done_pulses got %0d want 1", nm, n_done); end
      n_checks++; if (sb.size() !== 0) begin n_fail++; $display("FAIL %s missing_pixels got %0d want 0", nm, sb.size()); end
      n_checks++; if (mon_busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_after got %b want 0", nm, mon_busy); end
   endtask

   task automatic test_reset;
      @(negedge clk);
      rst_a = 1'b1; rst_b = 1'b1;
      ba.enable = 1'b1; ba.x_in = 8'd5; ba.y_in = 7'd5;
      @(negedge clk);
      ba.enable = 1'b0;
      @(negedge clk);
      rst_a = 1'b0; rst_b = 1'b0;
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sel = s;
         #1;
         n_checks++;
         if ({mon_x, mon_y, mon_c, mon_plot, mon_busy, mon_done} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_state sel=%0d got x=%0d y=%0d c=%b p=%b b=%b d=%b want all 0",
                     s, mon_x, mon_y, mon_c, mon_plot, mon_busy, mon_done);
         end
      end
      sel = 0;
   endtask

   task automatic test_first_frame;
      sel = 0;
      start(10, 20);
      n_checks++; if (mon_busy !== 1'b1) begin n_fail++; $display("FAIL first_busy got %b want 1", mon_busy); end
      drain(-1, 2);
      frame_checks("first_frame", 4, 2, 5, 5);
   endtask

   task automatic test_second_frame;
      sel = 0;
      start(12, 20);
      drain(-1, 2);
      frame_checks("second_frame", 8, 2, 9, 9);
   endtask

   task automatic test_clipping;
      sel = 0;
      start(159, 119);
      drain(-1, 2);
      frame_checks("clipping", 5, 2, 6, 9);
   endtask

   task automatic test_busy_ignore;
      sel = 0;
      start(40, 50);
      drain(2, 8);
      frame_checks("busy_ignore", 5, 2, 9, 9);
   endtask

   task automatic test_reset_mid_pass;
      pix_t e;
      int   cnt;
      sel = 0;
      cnt = 0;
      start(60, 70);
      for (int i = 0; i < 8; i++) begin
         if (mon_plot) begin
            cnt++;
            e = sb.pop_front();
            n_checks++;
            if ({mon_x, mon_y, mon_c} !== e) begin
               n_fail++;
               $display("FAIL midpass_pixel i=%0d got (%0d,%0d,%b) want (%0d,%0d,%b)", i, mon_x, mon_y, mon_c, e.x, e.y, e.c);
            end
         end
         if (i < 7) @(negedge clk);
      end
      n_checks++; if (cnt !== 6) begin n_fail++; $display("FAIL midpass_plots got %0d want 6", cnt); end
      rst_a = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({mon_plot, mon_busy, mon_done, mon_x, mon_y, mon_c} !== 21'd0) begin
         n_fail++;
         $display("FAIL midpass_reset got p=%b b=%b d=%b x=%0d y=%0d c=%b want all 0",
                  mon_plot, mon_busy, mon_done, mon_x, mon_y, mon_c);
      end
      rst_a = 1'b0;
      sb.delete();
      m_prev[0] = 1'b0;
      @(negedge clk);
      n_checks++; if (mon_plot !== 1'b0) begin n_fail++; $display("FAIL midpass_no_plot got %b want 0", mon_plot); end
      start(70, 80);
      drain(-1, 2);
      frame_checks("after_reset", 4, 2, 5, 5);
   endtask

   task automatic test_size_one;
      sel = 1;
      start(3, 4);
      drain(-1, 2);
      frame_checks("size1_first", 1, 2, 2, 2);
      start(5, 6);
      drain(-1, 2);
      frame_checks("size1_second", 2, 2, 3, 3);
   endtask

   initial begin
      sel = 0;
      rst_a = 1'b1; rst_b = 1'b1;
      ba.enable = 1'b0; ba.x_in = '0; ba.y_in = '0;
      bb.enable = 1'b0; bb.x_in = '0; bb.y_in = '0;
      m_prev[0] = 1'b0; m_prev[1] = 1'b0;
      test_reset;
      test_first_frame;
      test_second_frame;
      test_clipping;
      test_busy_ignore;
      test_reset_mid_pass;
      test_size_one;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

endmodule

// File: doc/ball_plotter.md
BALL_PLOTTER -- requirements
Module: ball_plotter

Interface
REQ-001 Parameter SIZE, default 2, is the ball edge length in pixels (legal 1..8).
REQ-002 Parameter BALL_COLOUR, default 3'b111, is the colour used for the draw pass.
REQ-003 Parameter BG_COLOUR, default 3'b000, is the colour used for the erase pass.
REQ-004 clk  input  1  is the single system clock (CLOCK_50 domain); all state changes on its rising edge.
REQ-005 reset  input  1  is the reset: one clock, synchronous, active-high.
REQ-006 enable  input  1  is the frame-tick pulse from the delay counter and requests one redraw.
REQ-007 x_in  input  8  is the ball top-left X from the position stage, range 0..159.
REQ-008 y_in  input  7  is the ball top-left Y from the position stage, range 0..119.
REQ-009 x  output  8  is the pixel X to the VGA adapter.
REQ-010 y  output  7  is the pixel Y to the VGA adapter.
REQ-011 colour  output  3  is the pixel colour to the VGA adapter.
REQ-012 plot  output  1  is the VGA write enable, one pixel per high cycle.
REQ-013 busy  output  1  is high while a redraw is in progress.
REQ-014 done  output  1  is a one-cycle pulse when a redraw completes.

Function
REQ-015 FSM states: IDLE, LOAD, ERASE, DRAW, FIN.
REQ-016 IDLE: when enable=1 at an edge, the block SHALL latch x_in/y_in into new_x/new_y and go to LOAD.
REQ-017 LOAD: the block SHALL clear dx and dy, then go to ERASE if prev_valid=1, otherwise to DRAW.
REQ-018 ERASE: each cycle the block SHALL emit pixel (old_x+dx, old_y+dy) with BG_COLOUR.
REQ-019 DRAW: each cycle the block SHALL emit pixel (new_x+dx, new_y+dy) with BALL_COLOUR.
REQ-020 Pixel order within a pass: row-major, dx increments fastest 0..SIZE-1, then dy increments, dx clears.
REQ-021 The erase pass SHALL end after SIZE*SIZE pixels; the block then clears dx and dy and enters DRAW.
REQ-022 The draw pass SHALL end after SIZE*SIZE pixels; the block then sets old_x/old_y to new_x/new_y, sets prev_valid=1, and enters FIN.
REQ-023 FIN: the block SHALL assert done for exactly one cycle and return to IDLE.
REQ-024 Outputs x, y, colour and plot SHALL be registered; the pixel for a counter value appears on the outputs one cycle after that value is held.
REQ-025 Pixel emission timing: plot high for exactly SIZE*SIZE consecutive cycles per pass; erase and draw passes back-to-back with no gap.
REQ-026 Per-redraw latency: enable sampled at edge k -> first plot high after edge k+2.
REQ-027 Per-redraw plot count: total plot cycles per redraw are 2*SIZE*SIZE, or SIZE*SIZE when prev_valid=0.
REQ-028 busy SHALL be high in LOAD, ERASE, DRAW and FIN, and low only in IDLE.
REQ-029 enable while busy=1 SHALL be ignored (not queued); x_in/y_in changes while busy SHALL NOT affect the frame in progress.
REQ-030 Clipping: a pixel with X sum > 159 or Y sum > 119 SHALL have plot=0 that cycle but still consumes its slot; sums computed 9/8 bits wide, no wrap.
REQ-031 When plot=0, x, y and colour SHALL hold their last values.
REQ-032 done and enable in the same cycle: in FIN, enable is ignored; in IDLE the next cycle, enable is accepted.

Reset
REQ-033 reset=1 at an edge SHALL force IDLE and clear dx, dy, prev_valid, old_x, old_y, new_x and new_y.
REQ-034 reset=1 at an edge SHALL clear x=0, y=0, colour=3'b000, plot=0, busy=0 and done=0.
REQ-035 reset mid-pass SHALL abort immediately with no further plot; the next redraw after reset performs no erase.
REQ-036 reset has priority over enable in the same cycle.

Verification
REQ-037 First frame, SIZE=2: reset, then enable with (10,20) -> exactly 4 plots (10,20),(11,20),(10,21),(11,21), colour 111, then done pulse.
REQ-038 Second frame: enable with (12,20) -> 4 erase plots at (10..11,20..21) colour 000, then 4 draw plots at (12..13,20..21) colour 111, 8 contiguous plot cycles, first plot after edge k+2.
REQ-039 Clipping: draw at (159,119) -> only pixel (159,119) plotted; the 3 slots with plot=0 still elapse; done 1 cycle after the 4th slot.
REQ-040 Busy-ignore: pulse enable again during ERASE with a different x_in -> no extra frame, no extra plots; drawn position is the first-latched value.
REQ-041 Reset mid-pass: assert reset during DRAW -> plot=0 next cycle, busy=0; the following enable yields only SIZE*SIZE draw plots.
REQ-042 SIZE=1 parameter run: two frames -> 1 plot, then 2 plots; done exactly once per frame.
